// File: rtl/ldtu_ser_rx.sv
// ldtu_ser_rx: single-lane receiver for one LiTE-DTU serializer stream.
// Hunts for the synchronisation pattern in the serial stream to find the
// 32-bit word boundary, confirms it over LockCount aligned matches, then
// delivers aligned words with a one-cycle valid strobe. While sync_mode is
// high it also checks each locked word and drops lock after UnlockCount
// consecutive mismatches.
module ldtu_ser_rx #(
   parameter int Nbits_32    = 32,
   parameter int LockCount   = 8,
   parameter int UnlockCount = 4
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                ser_in,
   input  logic                sync_mode,
   input  logic [Nbits_32-1:0] synch_pattern,
   input  logic                relock,
   output logic [Nbits_32-1:0] word_out,
   output logic                word_valid,
   output logic                word_is_synch,
   output logic                locked,
   output logic [1:0]          state,
   output logic [15:0]         err_cnt
);

   localparam int                CntW     = $clog2(Nbits_32);
   localparam logic [CntW-1:0]   LastBit  = CntW'(Nbits_32 - 1);
   localparam logic [CntW-1:0]   CntOne   = CntW'(1);
   localparam logic [7:0]        LockLim  = 8'(LockCount);
   localparam logic [7:0]        MissLim  = 8'(UnlockCount);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [Nbits_32-1:0] sr;
   logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]          match_q, match_d;
   logic [7:0]          miss_q, miss_d;
   logic [15:0]         err_cnt_q, err_cnt_d;
   logic [Nbits_32-1:0] word_out_q, word_out_d;
   logic                word_valid_d;
   logic                synch_q, synch_d;
   logic                locked_q;
   logic                pattern_hit;
   logic                boundary;

   assign pattern_hit = (sr == synch_pattern);
   assign boundary    = (bit_cnt_q == LastBit);

   // Serial shift register: one bit per clock, MSB of each word first.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge values, independent of block order.
         sr <= {sr[Nbits_32-2:0], ser_in};
      end
   end

   // Next-state and next-output logic for the alignment FSM.
   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // left one unassigned would infer a latch.
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      match_d      = match_q;
      miss_d       = miss_q;
      err_cnt_d    = err_cnt_q;
      word_out_d   = word_out_q;
      word_valid_d = 1'b0;
      synch_d      = synch_q;

      if (relock) begin
         // Abandon alignment; the pattern compare is ignored this cycle.
         state_d   = HUNT;
         bit_cnt_d = '0;
         match_d   = '0;
         miss_d    = '0;
      end else begin
         unique case (state_q)
            HUNT: begin
               bit_cnt_d = '0;
               if (pattern_hit) begin
                  state_d = CHECK;
                  match_d = 8'd1;
               end
            end

            CHECK: begin
               bit_cnt_d = bit_cnt_q + CntOne;
               if (boundary) begin
                  if (pattern_hit) begin
                     match_d = match_q + 8'd1;
                     if (match_q + 8'd1 == LockLim) begin
                        state_d = LOCKED;
                     end
                  end else begin
                     state_d = HUNT;
                     match_d = '0;
                  end
               end
            end

            LOCKED: begin
               bit_cnt_d = bit_cnt_q + CntOne;
               if (boundary) begin
                  word_out_d   = sr;
                  word_valid_d = 1'b1;
                  synch_d      = pattern_hit;
                  // With sync_mode low the stream carries data: no checking,
                  // and the miss counter is left alone.
                  if (sync_mode) begin
                     if (pattern_hit) begin
                        miss_d = '0;
                     end else begin
                        miss_d = miss_q + 8'd1;
                        if (err_cnt_q != 16'hFFFF) begin
                           err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (miss_q + 8'd1 == MissLim) begin
                           state_d = HUNT;
                           miss_d  = '0;
                           match_d = '0;
                        end
                     end
                  end
               end
            end

            default: begin
               state_d   = HUNT;
               bit_cnt_d = '0;
               match_d   = '0;
               miss_d    = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q    <= HUNT;
         bit_cnt_q  <= '0;
         match_q    <= '0;
         miss_q     <= '0;
         err_cnt_q  <= '0;
         word_out_q <= '0;
         word_valid <= 1'b0;
         synch_q    <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         err_cnt_q  <= err_cnt_d;
         word_out_q <= word_out_d;
         word_valid <= word_valid_d;
         synch_q    <= synch_d;
         locked_q   <= (state_d == LOCKED);
      end
   end

   assign state         = state_q;
   assign locked        = locked_q;
   assign err_cnt       = err_cnt_q;
   assign word_out      = word_out_q;
   assign word_is_synch = synch_q;

endmodule
